// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: entry layout, drain FSM states, ROB tag width and TBUS op encodings.
package store_buffer_pkg;

   localparam int ROB_SIZE_LOG  = 6;
   localparam int TBUS_OPTYPE_W = 2;

   localparam logic [TBUS_OPTYPE_W-1:0] TBUS_OP_READ  = 2'd0;
   localparam logic [TBUS_OPTYPE_W-1:0] TBUS_OP_WRITE = 2'd1;

   typedef struct packed {
      logic [63:0]             addr;
      logic [63:0]             data;
      logic [63:0]             mask;
      logic                    rob_flag;
      logic [ROB_SIZE_LOG-1:0] rob_idx;
   } sb_entry_t;

   typedef enum logic [1:0] {
      SB_IDLE = 2'd0,
      SB_REQ  = 2'd1,
      SB_WAIT = 2'd2
   } sb_state_e;

endpackage

// File: rtl/robidx_younger.sv
// ROB-age compare: o_younger is high when {i_flag,i_idx} is strictly younger than the flush tag.
// Purely combinational; equal tags are not younger.
module robidx_younger
   import store_buffer_pkg::*;
(
   input  logic                    i_flush_flag,
   input  logic [ROB_SIZE_LOG-1:0] i_flush_idx,
   input  logic                    i_flag,
   input  logic [ROB_SIZE_LOG-1:0] i_idx,
   output logic                    o_younger
);

   assign o_younger = (i_flush_flag ^ i_flag) ^ (i_flush_idx < i_idx);

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer draining committed stores to TBUS; index_valid one cycle after head commits,
// enq_ready = ~full from registered state. STORE_BUFFER_FWD_EN adds a combinational forwarding lookup.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int SB_DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [63:0]              enq_addr,
   input  logic [63:0]              enq_data,
   input  logic [63:0]              enq_mask,
   input  logic                     enq_robidx_flag,
   input  logic [ROB_SIZE_LOG-1:0]  enq_robidx,
   input  logic                     commit_valid,
   input  logic                     flush_valid,
   input  logic                     flush_robidx_flag,
   input  logic [ROB_SIZE_LOG-1:0]  flush_robidx,
   output logic                     sb2arb_tbus_index_valid,
   input  logic                     sb2arb_tbus_index_ready,
   output logic [63:0]              sb2arb_tbus_index,
   output logic [63:0]              sb2arb_tbus_write_data,
   output logic [63:0]              sb2arb_tbus_write_mask,
   input  logic                     sb2arb_tbus_operation_done,
   output logic [TBUS_OPTYPE_W-1:0] sb2arb_tbus_operation_type,
   output logic                     sb_empty
`ifdef STORE_BUFFER_FWD_EN
   ,
   input  logic [63:0]              fwd_addr,
   output logic [63:0]              fwd_data,
   output logic [63:0]              fwd_mask
`endif
);

   localparam int IDX_W = $clog2(SB_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   sb_entry_t           r_ent [SB_DEPTH];
   logic [SB_DEPTH-1:0] r_vld, r_cmt;
   logic [PTR_W-1:0]    r_head, r_tail, r_cptr;
   sb_state_e           r_state;

   sb_state_e           w_state_nxt;
   logic [IDX_W-1:0]    w_head_idx;
   logic                w_full, w_has_uncmt, w_commit, w_pop, w_enq_young, w_enq_fire, w_found;
   logic [PTR_W-1:0]    w_cptr_nxt, w_uncmt_cnt, w_flush_tail, w_pos;
   logic [SB_DEPTH-1:0] w_young, w_kill;
   logic                w_unused_lsb;

   assign w_head_idx   = r_head[IDX_W-1:0];
   assign w_full       = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) && (r_head[IDX_W] != r_tail[IDX_W]);
   assign sb_empty     = (r_head == r_tail);
   assign enq_ready    = ~w_full;
   assign w_has_uncmt  = (r_cptr != r_tail);
   assign w_commit     = commit_valid & w_has_uncmt;
   assign w_cptr_nxt   = r_cptr + (w_commit ? PTR_ONE : '0);
   assign w_uncmt_cnt  = r_tail - w_cptr_nxt;
   assign w_pop        = (r_state == SB_WAIT) & sb2arb_tbus_operation_done;
   assign w_unused_lsb = ^r_ent[w_head_idx].addr[2:0];

   for (genvar g = 0; g < SB_DEPTH; g++) begin : g_age
      robidx_younger u_age (
         .i_flush_flag (flush_robidx_flag),
         .i_flush_idx  (flush_robidx),
         .i_flag       (r_ent[g].rob_flag),
         .i_idx        (r_ent[g].rob_idx),
         .o_younger    (w_young[g])
      );
   end

   robidx_younger u_enq_age (
      .i_flush_flag (flush_robidx_flag),
      .i_flush_idx  (flush_robidx),
      .i_flag       (enq_robidx_flag),
      .i_idx        (enq_robidx),
      .o_younger    (w_enq_young)
   );

   // Uncommitted entries are age-ordered, so the first younger one marks the new tail.
   always_comb begin
      w_flush_tail = r_tail;
      w_found      = 1'b0;
      w_kill       = '0;
      w_pos        = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         w_pos = w_cptr_nxt + PTR_W'(k);
         if (flush_valid && (PTR_W'(k) < w_uncmt_cnt) && w_young[w_pos[IDX_W-1:0]]) begin
            w_kill[w_pos[IDX_W-1:0]] = 1'b1;
            if (!w_found) begin
               w_found      = 1'b1;
               w_flush_tail = w_pos;
            end
         end
      end
   end

   assign w_enq_fire = enq_valid & ~w_full & ~(flush_valid & w_enq_young);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vld  <= '0;
         r_cmt  <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_cptr <= '0;
      end else begin
         assert (!(commit_valid && !w_has_uncmt));
         r_vld <= r_vld & ~w_kill;
         if (w_pop) begin
            r_vld[w_head_idx] <= 1'b0;
            r_cmt[w_head_idx] <= 1'b0;
            r_head            <= r_head + PTR_ONE;
         end
         if (w_commit) r_cmt[r_cptr[IDX_W-1:0]] <= 1'b1;
         if (w_enq_fire) begin
            r_vld[w_flush_tail[IDX_W-1:0]] <= 1'b1;
            r_cmt[w_flush_tail[IDX_W-1:0]] <= 1'b0;
         end
         r_tail <= w_flush_tail + (w_enq_fire ? PTR_ONE : '0);
         r_cptr <= w_cptr_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (w_enq_fire) begin
         r_ent[w_flush_tail[IDX_W-1:0]] <= '{addr: enq_addr, data: enq_data, mask: enq_mask,
                                             rob_flag: enq_robidx_flag, rob_idx: enq_robidx};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= SB_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt                = r_state;
      sb2arb_tbus_index_valid    = 1'b0;
      sb2arb_tbus_index          = '0;
      sb2arb_tbus_write_data     = '0;
      sb2arb_tbus_write_mask     = '0;
      sb2arb_tbus_operation_type = TBUS_OP_READ;
      case (r_state)
         SB_IDLE: if (r_vld[w_head_idx] && r_cmt[w_head_idx]) w_state_nxt = SB_REQ;
         SB_REQ: begin
            sb2arb_tbus_index_valid    = 1'b1;
            sb2arb_tbus_index          = {r_ent[w_head_idx].addr[63:3], 3'b000};
            sb2arb_tbus_write_data     = r_ent[w_head_idx].data;
            sb2arb_tbus_write_mask     = r_ent[w_head_idx].mask;
            sb2arb_tbus_operation_type = TBUS_OP_WRITE;
            if (sb2arb_tbus_index_ready) w_state_nxt = SB_WAIT;
         end
         SB_WAIT: if (sb2arb_tbus_operation_done) w_state_nxt = SB_IDLE;
         default: w_state_nxt = SB_IDLE;
      endcase
   end

`ifdef STORE_BUFFER_FWD_EN
   logic             w_unused_fwd;
   logic [IDX_W-1:0] w_fidx;
   assign w_unused_fwd = ^fwd_addr[2:0];

   // Walk oldest to youngest so younger stores overwrite each byte they touch.
   always_comb begin
      fwd_data = '0;
      fwd_mask = '0;
      w_fidx   = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         w_fidx = w_head_idx + IDX_W'(k);
         if (r_vld[w_fidx] && (r_ent[w_fidx].addr[63:3] == fwd_addr[63:3])) begin
            for (int b = 0; b < 8; b++) begin
               if (|r_ent[w_fidx].mask[8*b +: 8]) begin
                  fwd_mask[8*b +: 8] = r_ent[w_fidx].mask[8*b +: 8];
                  fwd_data[8*b +: 8] = r_ent[w_fidx].data[8*b +: 8] & r_ent[w_fidx].mask[8*b +: 8];
               end
            end
         end
      end
   end
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 8, number of store entries (power of two, 2..16).
REQ-002 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have enq_valid in 1 and enq_ready out 1, the store-enqueue handshake from memblock.
REQ-005 SHALL have enq_addr in 64 (store address), enq_data in 64 (byte-shifted data) and enq_mask in 64 (bit-level write mask).
REQ-006 SHALL have enq_robidx_flag in 1 and enq_robidx in ROB_SIZE_LOG, the store's ROB tag.
REQ-007 SHALL have commit_valid in 1, asserted when the ROB retires the oldest store.
REQ-008 SHALL have flush_valid in 1, flush_robidx_flag in 1 and flush_robidx in ROB_SIZE_LOG, the redirect flush.
REQ-009 SHALL have sb2arb_tbus_index_valid out 1, sb2arb_tbus_index_ready in 1 and sb2arb_tbus_index out 64.
REQ-010 SHALL have sb2arb_tbus_write_data out 64, sb2arb_tbus_write_mask out 64, sb2arb_tbus_operation_done in 1 and sb2arb_tbus_operation_type out TBUS_OPTYPE width.
REQ-011 SHALL have sb_empty out 1, high when no entry is valid.

Function
REQ-012 SHALL be a circular FIFO with head/tail pointers plus wrap bit; each entry holds addr, data, mask, robidx flag/idx and a committed bit.
REQ-013 SHALL drive enq_ready = ~full, computed from registered state; a same-cycle dequeue SHALL NOT raise enq_ready.
REQ-014 On enq_valid & enq_ready, SHALL write the entry at tail with committed=0 and advance tail.
REQ-015 Commit pointer: on commit_valid, SHALL set committed=1 on the oldest uncommitted entry; commit_valid with no uncommitted entry is ignored and flagged by an assertion.
REQ-016 Flush: an entry is younger when (flush_robidx_flag ^ robidx_flag) ^ (flush_robidx < robidx); equal tags are not younger.
REQ-017 On flush_valid, SHALL invalidate every uncommitted younger entry and move tail to the oldest invalidated slot; committed entries SHALL never be flushed.
REQ-018 Simultaneous commit and flush: commit applies first. Simultaneous enq and flush: a younger enq is dropped, an older enq is written.
REQ-019 Drain FSM: IDLE -> REQ when the head entry is valid and committed; REQ -> WAIT on index_valid & index_ready; WAIT -> IDLE on operation_done, popping head in that cycle.
REQ-020 In REQ, SHALL hold index_valid=1 with index={addr[63:3],3'b000}, write_data, write_mask and operation_type = TBUS write encoding, all stable until accepted.
REQ-021 SHALL assert index_valid one cycle after the head becomes committed.
REQ-022 Outside REQ, SHALL drive index_valid=0 and operation_type = TBUS read encoding.
REQ-023 Full and empty SHALL be distinguished by pointer wrap bits, and the pointers SHALL wrap from SB_DEPTH-1 to 0 correctly.

Reset
REQ-024 On reset_n low, SHALL asynchronously clear all valid/committed bits, pointers to 0 and FSM to IDLE; outputs SHALL read enq_ready=1, sb_empty=1, index_valid=0, and index/data/mask=0.
REQ-025 Reset mid-drain SHALL abandon the transaction with no pop; it is the arbiter's duty to drop any in-flight request.

Configuration
REQ-026 With STORE_BUFFER_FWD_EN defined, SHALL add ports fwd_addr in 64, fwd_data out 64 and fwd_mask out 64 as a combinational load-forwarding lookup.
REQ-027 The lookup SHALL byte-merge all valid entries whose addr[63:3] equals fwd_addr[63:3], with the youngest entry winning per byte; unmatched bytes give mask 0 and data 0.
REQ-028 Without STORE_BUFFER_FWD_EN, the forwarding ports and logic SHALL be absent.

Structure
REQ-029 The sb_entry_t typedef, the SB FSM state enum and the TBUS optype read/write encodings SHALL live in the shared package/defines.
REQ-030 The ROB-age compare SHALL live in one sub-module, robidx_younger, shared with the flush logic of other units.

Verification
REQ-031 Enq one store (addr 0x80001004, mask 0x00000000FFFFFFFF<<32), then commit -> index_valid next cycle, index 0x80001000; done pops it and sb_empty=1.
REQ-032 Enq 8 stores with no commit -> enq_ready=0; 9th enq ignored; one commit plus drain -> enq_ready returns the cycle after the pop.
REQ-033 Entries with robidx 3,4,5 (flag 0), commit 1, flush robidx 3 -> robidx 4 and 5 removed, tail=1, robidx 3 still drains.
REQ-034 Commit and flush in the same cycle on robidx 2 with flush tag 1 -> robidx 2 committed and kept; younger entries flushed.
REQ-035 Hold index_ready=0 for 5 cycles -> index, data and mask stable; wrap test with 20 enq/commit/drain cycles -> in-order addresses and no loss.
REQ-036 With STORE_BUFFER_FWD_EN, stores byte0=0x11 then byte0=0x22 to 0x80002000, lookup 0x80002000 -> fwd_mask=0xFF and fwd_data[7:0]=0x22.
